// File: rtl/noc_pkg.sv
// Shared NoC definitions: header field placement, packetizer FSM states and
// mesh port direction encodings.
package noc_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PAYLOAD = 1'b1
  } pkt_state_e;

  // Header layout, MSB first: dest | src | len | zero fill.
  function automatic int hdr_dest_lsb(input int flit_w, input int dest_w);
    return flit_w - dest_w;
  endfunction

  function automatic int hdr_src_lsb(input int flit_w, input int dest_w);
    return flit_w - 2 * dest_w;
  endfunction

  function automatic int hdr_len_lsb(input int flit_w, input int dest_w, input int len_w);
    return flit_w - 2 * dest_w - len_w;
  endfunction

  // Router port directions, one-hot, shared with the mesh.
  localparam int DIR_COUNT = 5;
  typedef logic [DIR_COUNT-1:0] dir_t;

  localparam dir_t DIR_LOCAL = 5'b00001;
  localparam dir_t DIR_NORTH = 5'b00010;
  localparam dir_t DIR_EAST  = 5'b00100;
  localparam dir_t DIR_SOUTH = 5'b01000;
  localparam dir_t DIR_WEST  = 5'b10000;

endpackage

// File: rtl/noc_flit_reg.sv
// Single-entry flit register with one-hot per-VC valid; drains on the selected
// VC's ready and can be reloaded in the cycle it drains.
module noc_flit_reg #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2,
  localparam int VC_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_flit,
  input  logic                load_last,
  input  logic [VC_W-1:0]     load_vc,
  output logic [WIDTH-1:0]    flit,
  output logic                last,
  output logic [CHANNELS-1:0] valid,
  input  logic [CHANNELS-1:0] ready,
  output logic                occ,
  output logic                drain,
  output logic                can_load
);

  logic [CHANNELS-1:0] vc_sel;

  always_comb begin
    vc_sel          = '0;
    vc_sel[load_vc] = 1'b1;
  end

  // Valid is only ever one-hot or zero, so masking with ready picks out the
  // selected VC and ignores ready on every other VC.
  assign occ      = |valid;
  assign drain    = |(valid & ready);
  assign can_load = !occ || drain;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      flit  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= vc_sel;
      flit  <= load_flit;
      last  <= load_last;
    end else if (drain) begin
      valid <= '0;
    end
  end

endmodule

// File: rtl/noc_local_packetizer.sv
// Injection-side adapter: turns a core command plus payload stream into one
// wormhole packet on the router LOCAL port. Optional NOC_PKT_STATS_EN adds pkt_cnt.
//
// state   | meaning
// IDLE    | waiting for a command; header loaded on accept (len==0 stays here)
// PAYLOAD | header sent, forwarding 'rem' remaining payload flits
module noc_local_packetizer
  import noc_pkg::*;
#(
  parameter int FLIT_WIDTH = 32,
  parameter int CHANNELS   = 2,
  parameter int NODES      = 16,
  parameter int NODE_ID    = 0,
  parameter int MAX_LEN    = 255,
  localparam int DEST_W    = $clog2(NODES),
  localparam int LEN_W     = $clog2(MAX_LEN + 1),
  localparam int VC_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DEST_W-1:0]     cmd_dest,
  input  logic [VC_W-1:0]       cmd_vc,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic [FLIT_WIDTH-1:0] data_flit,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic                  out_last,
  output logic [CHANNELS-1:0]   out_valid,
  input  logic [CHANNELS-1:0]   out_ready,
  output logic                  busy,
  output logic                  err
`ifdef NOC_PKT_STATS_EN
  ,
  output logic [31:0]           pkt_cnt
`endif
);

  localparam int DEST_LSB = hdr_dest_lsb(FLIT_WIDTH, DEST_W);
  localparam int SRC_LSB  = hdr_src_lsb(FLIT_WIDTH, DEST_W);
  localparam int LEN_LSB  = hdr_len_lsb(FLIT_WIDTH, DEST_W, LEN_W);

  localparam logic [DEST_W:0]   NODES_L = (DEST_W + 1)'(NODES);
  localparam logic [DEST_W-1:0] SRC_ID  = DEST_W'(NODE_ID);

  pkt_state_e             state;
  logic [LEN_W-1:0]       rem;
  logic [VC_W-1:0]        vc_q;

  logic                   occ;
  logic                   drain;
  logic                   can_load;

  logic                   dest_ok;
  logic                   cmd_fire;
  logic                   hdr_load;
  logic                   data_fire;
  logic                   load;
  logic [FLIT_WIDTH-1:0]  hdr;
  logic [FLIT_WIDTH-1:0]  load_flit;
  logic                   load_last;
  logic [VC_W-1:0]        load_vc;

  always_comb begin
    hdr                        = '0;
    hdr[DEST_LSB +: DEST_W]    = cmd_dest;
    hdr[SRC_LSB +: DEST_W]     = SRC_ID;
    hdr[LEN_LSB +: LEN_W]      = cmd_len;
  end

  // Handshakes are held low while reset is asserted.
  assign dest_ok    = {1'b0, cmd_dest} < NODES_L;
  assign cmd_ready  = !rst && (state == IDLE) && can_load;
  assign data_ready = !rst && (state == PAYLOAD) && can_load && (rem != '0);

  assign cmd_fire   = cmd_valid && cmd_ready;
  assign hdr_load   = cmd_fire && dest_ok;
  assign data_fire  = data_valid && data_ready;
  assign load       = hdr_load || data_fire;

  assign load_flit  = hdr_load ? hdr : data_flit;
  assign load_last  = hdr_load ? (cmd_len == '0) : (rem == LEN_W'(1));
  assign load_vc    = hdr_load ? cmd_vc : vc_q;

  assign busy       = (state != IDLE) || occ;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem   <= '0;
      vc_q  <= '0;
      err   <= 1'b0;
    end else begin
      err <= cmd_fire && !dest_ok;
      case (state)
        IDLE: begin
          if (hdr_load && (cmd_len != '0)) begin
            state <= PAYLOAD;
            rem   <= cmd_len;
            vc_q  <= cmd_vc;
          end
        end
        PAYLOAD: begin
          if (data_fire) begin
            rem <= rem - LEN_W'(1);
            if (rem == LEN_W'(1)) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  noc_flit_reg #(
    .WIDTH    (FLIT_WIDTH),
    .CHANNELS (CHANNELS)
  ) u_flit_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_flit (load_flit),
    .load_last (load_last),
    .load_vc   (load_vc),
    .flit      (out_flit),
    .last      (out_last),
    .valid     (out_valid),
    .ready     (out_ready),
    .occ       (occ),
    .drain     (drain),
    .can_load  (can_load)
  );

`ifdef NOC_PKT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else if (drain && out_last) begin
      pkt_cnt <= pkt_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_noc_local_packetizer.sv
// Self-checking bench for noc_local_packetizer: directed scenarios then random
// packets scored against an expected-flit queue. Honors NOC_PKT_STATS_EN.
module tb_noc_local_packetizer;

  localparam int FW      = 32;
  localparam int CH      = 2;
  localparam int NODES   = 12;
  localparam int NODE_ID = 3;
  localparam int MAX_LEN = 255;
  localparam int DW      = 4;
  localparam int LW      = 8;
  localparam int VW      = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_dest;
  logic [VW-1:0] cmd_vc;
  logic [LW-1:0] cmd_len;
  logic [FW-1:0] data_flit;
  logic          data_valid;
  logic          data_ready;
  logic [FW-1:0] out_flit;
  logic          out_last;
  logic [CH-1:0] out_valid;
  logic [CH-1:0] out_ready;
  logic          busy;
  logic          err;
`ifdef NOC_PKT_STATS_EN
  logic [31:0]   pkt_cnt;
`endif

  always #5 clk = ~clk;

  noc_local_packetizer #(
    .FLIT_WIDTH (FW),
    .CHANNELS   (CH),
    .NODES      (NODES),
    .NODE_ID    (NODE_ID),
    .MAX_LEN    (MAX_LEN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dest   (cmd_dest),
    .cmd_vc     (cmd_vc),
    .cmd_len    (cmd_len),
    .data_flit  (data_flit),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .out_flit   (out_flit),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .err        (err)
`ifdef NOC_PKT_STATS_EN
    ,
    .pkt_cnt    (pkt_cnt)
`endif
  );

  typedef struct {
    logic [FW-1:0] flit;
    logic          last;
    logic [CH-1:0] valid;
  } exp_t;

  exp_t          exp_q[$];
  logic [FW-1:0] pl[$];
  int            checks    = 0;
  int            failures  = 0;
  int            cyc       = 0;
  int            acc_cyc   = 0;
  int            exp_pkts  = 0;
  bit            rand_rdy  = 1'b0;
  bit            gaps      = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk_hdr(input int dest, input int len);
    logic [63:0] h;
    h = (64'(dest) << (FW - DW)) | (64'(NODE_ID) << (FW - 2 * DW)) |
        (64'(len) << (FW - 2 * DW - LW));
    return h[FW-1:0];
  endfunction

  function automatic logic [CH-1:0] vc_onehot(input int vc);
    logic [CH-1:0] one;
    one = 1;
    return one << vc;
  endfunction

  // Scoreboard: every drained flit must be the next expected one; an occupied,
  // undrained register must hold flit/last/valid until it drains.
  logic [FW-1:0] p_flit;
  logic          p_last;
  logic [CH-1:0] p_valid;
  bit            p_hold = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      p_hold <= 1'b0;
    end else begin
      chk("valid_onehot", 64'($countones(out_valid) <= 1), 64'd1);
      if (p_hold) begin
        chk("hold_flit", 64'(out_flit), 64'(p_flit));
        chk("hold_last", 64'(out_last), 64'(p_last));
        chk("hold_valid", 64'(out_valid), 64'(p_valid));
      end
      if (|(out_valid & out_ready)) begin
        chk("flit_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("drain_flit", 64'(out_flit), 64'(e.flit));
          chk("drain_last", 64'(out_last), 64'(e.last));
          chk("drain_valid", 64'(out_valid), 64'(e.valid));
        end
      end
      p_hold  <= (out_valid != '0) && !(|(out_valid & out_ready));
      p_flit  <= out_flit;
      p_last  <= out_last;
      p_valid <= out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = CH'($urandom);
  endtask

  task automatic gen_pl(input int len);
    pl.delete();
    for (int i = 0; i < len; i++) pl.push_back($urandom);
  endtask

  task automatic queue_pkt(input int dest, input int vc, input int len);
    exp_t e;
    e.flit  = mk_hdr(dest, len);
    e.last  = (len == 0);
    e.valid = vc_onehot(vc);
    exp_q.push_back(e);
    for (int i = 0; i < len; i++) begin
      e.flit = pl[i];
      e.last = (i == len - 1);
      exp_q.push_back(e);
    end
    exp_pkts++;
  endtask

  // Called one time unit after an edge; returns one time unit after the accept edge.
  task automatic send_cmd(input int dest, input int vc, input int len);
    int n = 0;
    bit fired = 1'b0;
    cmd_valid = 1'b1;
    cmd_dest  = DW'(dest);
    cmd_vc    = VW'(vc);
    cmd_len   = LW'(len);
    do begin
      #1;
      fired = cmd_ready;
      tick();
      n++;
    end while (!fired && n < 200);
    cmd_valid = 1'b0;
    acc_cyc   = cyc;
    chk("cmd_accept", 64'(fired), 64'd1);
    if (dest < NODES) begin
      chk("hdr_valid", 64'(out_valid), 64'(vc_onehot(vc)));
      chk("hdr_flit", 64'(out_flit), 64'(mk_hdr(dest, len)));
      chk("hdr_last", 64'(out_last), 64'(len == 0));
    end else begin
      chk("err_pulse", 64'(err), 64'd1);
      chk("drop_no_valid", 64'(out_valid), 64'd0);
      tick();
      chk("err_one_cycle", 64'(err), 64'd0);
    end
  endtask

  task automatic send_data(input logic [FW-1:0] flit, input bit last, input int vc);
    int n = 0;
    bit fired = 1'b0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        data_valid = 1'b0;
        tick();
      end
    end
    data_valid = 1'b1;
    data_flit  = flit;
    do begin
      #1;
      fired = data_ready;
      tick();
      n++;
    end while (!fired && n < 200);
    data_valid = 1'b0;
    chk("data_accept", 64'(fired), 64'd1);
    chk("data_flit", 64'(out_flit), 64'(flit));
    chk("data_last", 64'(out_last), 64'(last));
    chk("data_valid_vc", 64'(out_valid), 64'(vc_onehot(vc)));
  endtask

  task automatic send_pkt(input int dest, input int vc, input int len);
    if (dest < NODES) queue_pkt(dest, vc, len);
    send_cmd(dest, vc, len);
    if (dest < NODES) begin
      for (int i = 0; i < len; i++) send_data(pl[i], (i == len - 1), vc);
    end
  endtask

  task automatic drain_all();
    rand_rdy  = 1'b0;
    out_ready = '1;
    repeat (10) tick();
    chk("all_drained", 64'(exp_q.size()), 64'd0);
    chk("idle_not_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int c1;
    logic [FW-1:0] d0, d1, d2;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_dest   = '0;
    cmd_vc     = '0;
    cmd_len    = '0;
    data_flit  = '0;
    data_valid = 1'b0;
    out_ready  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_data_ready", 64'(data_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_flit", 64'(out_flit), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
`ifdef NOC_PKT_STATS_EN
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
`endif
    rst = 1'b0;
    #1;
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    tick();

    // Basic packet: dest 5, vc 1, three payload flits, router ready on vc 1 only.
    out_ready = 2'b10;
    pl.delete();
    pl.push_back(32'hAAAA_0001);
    pl.push_back(32'hBBBB_0002);
    pl.push_back(32'hCCCC_0003);
    send_pkt(5, 1, 3);
    drain_all();

    // Zero-length packets: headers back to back, next command taken as header drains.
    out_ready = 2'b11;
    gen_pl(0);
    send_pkt(2, 0, 0);
    c1 = acc_cyc;
    send_pkt(7, 1, 0);
    chk("b2b_hdr_gap", 64'(acc_cyc - c1), 64'd1);
    data_valid = 1'b1;
    #1;
    chk("idle_data_ready", 64'(data_ready), 64'd0);
    tick();
    data_valid = 1'b0;
    drain_all();

    // Router stalls vc 1 for five cycles mid-payload.
    out_ready = 2'b11;
    gen_pl(3);
    d0 = pl[0];
    d1 = pl[1];
    d2 = pl[2];
    queue_pkt(4, 1, 3);
    send_cmd(4, 1, 3);
    send_data(d0, 1'b0, 1);
    out_ready  = 2'b01;
    data_valid = 1'b1;
    data_flit  = d1;
    repeat (5) begin
      #1;
      chk("stall_data_ready", 64'(data_ready), 64'd0);
      chk("stall_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("stall_valid", 64'(out_valid), 64'b10);
      chk("stall_busy", 64'(busy), 64'd1);
      tick();
    end
    data_valid = 1'b0;
    out_ready  = 2'b11;
    send_data(d1, 1'b0, 1);
    send_data(d2, 1'b1, 1);
    drain_all();

    // VC 0 selected while only vc 1 is ready: nothing may drain.
    out_ready = 2'b10;
    gen_pl(0);
    queue_pkt(1, 0, 0);
    send_cmd(1, 0, 0);
    repeat (3) begin
      #1;
      chk("wrong_vc_valid", 64'(out_valid), 64'b01);
      chk("wrong_vc_cmd_ready", 64'(cmd_ready), 64'd0);
      tick();
    end
    drain_all();

    // Out-of-range destination, then boundary and loopback destinations.
    out_ready = 2'b11;
    gen_pl(2);
    send_pkt(13, 1, 2);
    gen_pl(2);
    send_pkt(NODES - 1, 0, 2);
    gen_pl(1);
    send_pkt(NODE_ID, 1, 1);
    drain_all();

    // Reset during payload flit 2 of 4.
    out_ready = 2'b11;
    gen_pl(4);
    queue_pkt(6, 1, 4);
    send_cmd(6, 1, 4);
    send_data(pl[0], 1'b0, 1);
    send_data(pl[1], 1'b0, 1);
    rst        = 1'b1;
    data_valid = 1'b1;
    data_flit  = pl[2];
    #1;
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("midrst_data_ready", 64'(data_ready), 64'd0);
    tick();
    exp_q.delete();
    exp_pkts = 0;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_last", 64'(out_last), 64'd0);
    chk("midrst_out_flit", 64'(out_flit), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
`ifdef NOC_PKT_STATS_EN
    chk("midrst_pkt_cnt", 64'(pkt_cnt), 64'd0);
`endif
    rst = 1'b0;
    #1;
    chk("midrst_idle_no_consume", 64'(data_ready), 64'd0);
    tick();
    data_valid = 1'b0;
    gen_pl(2);
    send_pkt(8, 0, 2);
    drain_all();
`ifdef NOC_PKT_STATS_EN
    chk("pkt_cnt_one", 64'(pkt_cnt), 64'd1);
`endif

    // Random packets with random router backpressure and payload gaps.
    rand_rdy = 1'b1;
    gaps     = 1'b1;
    repeat (40) begin
      int dest, vc, len;
      dest = $urandom_range(0, 15);
      vc   = $urandom_range(0, CH - 1);
      len  = $urandom_range(0, 6);
      gen_pl(len);
      send_pkt(dest, vc, len);
    end
    gaps = 1'b0;
    drain_all();
`ifdef NOC_PKT_STATS_EN
    chk("pkt_cnt_random", 64'(pkt_cnt), 64'(exp_pkts));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
